core_bus_arbiter: RTL

Two-master to one-slave Wishbone (classic, single-cycle strobe) arbiter placed between a core and the Controller's `core_*` memory port. It lets cores with separate instruction-fetch and data buses share the single Controller memory interface when the second memory is not used. It serialises requests, holds a grant until the slave acknowledges, and aborts stalled transfers with an error after a programmable timeout.

---
 rtl/core_bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: two-master to one-slave Wishbone classic arbiter.
// Serialises m0 (fetch) and m1 (data) requests onto a single slave port. The grant is held
// until the slave acks, the master drops cyc, or a programmable timeout fires.
// Optional feature: define CORE_BUS_ARBITER_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, m1 always wins over m0 on simultaneous requests.
module core_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);
    localparam bit TmoEn = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e              state_q;
    logic [1:0]          grant_q;
    logic [CntWidth-1:0] cnt_q;

    logic req0, req1;
    logic pick1;
    logic cyc_cur;
    logic tmo_hit;
    logic tmo_fire;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    assign cyc_cur  = grant_q[1] ? m1_cyc_i : m0_cyc_i;
    assign tmo_hit  = TmoEn && (state_q != StIdle) && (cnt_q == CntLast);
    // A same-cycle ack takes precedence over the timeout.
    assign tmo_fire = tmo_hit & ~s_ack_i;

`ifdef CORE_BUS_ARBITER_ROUND_ROBIN_EN
    logic last_m1_q;

    // On contention, serve whichever master was not served last.
    assign pick1 = req1 & (~req0 | ~last_m1_q);

    // Remember which master received the most recent grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_m1_q <= 1'b1;
        end else if ((state_q == StIdle) && (req0 || req1)) begin
            last_m1_q <= pick1;
        end
    end
`else
    // Fixed priority: the data port always wins.
    assign pick1 = req1;
`endif

    // Grant FSM with timeout counter; grant_q mirrors the state one-hot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (pick1) begin
                        state_q <= StGnt1;
                        grant_q <= 2'b10;
                    end else if (req0) begin
                        state_q <= StGnt0;
                        grant_q <= 2'b01;
                    end
                end
                StGnt0, StGnt1: begin
                    if (s_ack_i || !cyc_cur || tmo_hit) begin
                        state_q <= StIdle;
                        grant_q <= 2'b00;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign grant_o = grant_q;

    // Route the granted master to the slave and the slave response back.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        if (grant_q[0]) begin
            s_cyc_o   = req0 & ~tmo_fire;
            s_stb_o   = req0 & ~tmo_fire;
            s_we_o    = m0_we_i;
            s_addr_o  = m0_addr_i;
            s_data_o  = m0_data_i;
            m0_data_o = s_data_i;
            m0_ack_o  = s_ack_i;
            m0_err_o  = tmo_fire;
        end else if (grant_q[1]) begin
            s_cyc_o   = req1 & ~tmo_fire;
            s_stb_o   = req1 & ~tmo_fire;
            s_we_o    = m1_we_i;
            s_addr_o  = m1_addr_i;
            s_data_o  = m1_data_i;
            m1_data_o = s_data_i;
            m1_ack_o  = s_ack_i;
            m1_err_o  = tmo_fire;
        end
    end

endmodule
